// File: rtl/proc_pkg.sv
// Shared pipeline types: forwarding-select encoding and the per-stage hazard record.
package proc_pkg;

    localparam int HZ_RD_W = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_X    = 2'd1,
        FWD_M    = 2'd2,
        FWD_W    = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               we;
        logic               ready;
        logic               is_long;
    } hz_stage_t;

endpackage

// File: rtl/pipe_hazard_unit_long_op_scoreboard.sv
// Pending-register scoreboard and outstanding-count tracker for long-latency (mul/div) results.
module long_op_scoreboard
    import proc_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int MAX_LONG_OPS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  set_i,
    input  logic [REG_ADDR_W-1:0] set_rd_i,
    input  logic                  inc_i,
    input  logic                  done_i,
    input  logic [REG_ADDR_W-1:0] done_rd_i,
    input  logic [REG_ADDR_W-1:0] look_rs1_i,
    input  logic [REG_ADDR_W-1:0] look_rs2_i,
    input  logic [REG_ADDR_W-1:0] look_rd_i,
    output logic                  pend_rs1_o,
    output logic                  pend_rs2_o,
    output logic                  pend_rd_o,
    output logic [2:0]            long_cnt_o,
    output logic                  long_busy_o,
    output logic                  err_o
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                done_ok;

    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_ok   = done_i && (done_rd_i != '0) && pending_q[done_rd_i];
        if (done_i && !done_ok) begin
            err_d = 1'b1;
        end
        // Clear before set so a retiring register can be reclaimed by a newly committed op.
        if (done_ok) begin
            pending_d[done_rd_i] = 1'b0;
        end
        if (set_i) begin
            pending_d[set_rd_i] = 1'b1;
        end
        case ({inc_i, done_ok})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign pend_rs1_o  = pending_q[look_rs1_i];
    assign pend_rs2_o  = pending_q[look_rs2_i];
    assign pend_rd_o   = pending_q[look_rd_i];
    assign long_cnt_o  = cnt_q;
    assign long_busy_o = (cnt_q == 3'(MAX_LONG_OPS));
    assign err_o       = err_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding unit: tracks X/M/W results, picks forwarding sources, and raises stalls.
module pipe_hazard_unit
    import proc_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int FWD_EN       = 1,
    parameter int MAX_LONG_OPS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  d_valid_i,
    input  logic [REG_ADDR_W-1:0] d_rs1_i,
    input  logic [REG_ADDR_W-1:0] d_rs2_i,
    input  logic                  d_rs1_used_i,
    input  logic                  d_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] d_rd_i,
    input  logic                  d_rd_we_i,
    input  logic                  d_is_load_i,
    input  logic                  d_is_long_i,
    input  logic                  flush_i,
    input  logic                  hold_i,
    input  logic                  long_done_i,
    input  logic [REG_ADDR_W-1:0] long_done_rd_i,
    output logic                  stall_o,
    output logic                  issue_o,
    output logic [1:0]            fwd_rs1_sel_o,
    output logic [1:0]            fwd_rs2_sel_o,
    output logic                  long_busy_o,
    output logic                  err_o
);

    hz_stage_t  x_q, m_q, w_q, x_d, m_d, w_d;
    logic [2:0] rs1_chk, rs2_chk, long_cnt;
    logic       pend_rs1, pend_rs2, pend_rd, long_limit, any_stall, adv_long;

    // Returns {stall, fwd_sel}; the youngest matching stage alone decides.
    function automatic logic [2:0] src_check(input logic used, input logic [HZ_RD_W-1:0] rs,
                                             input hz_stage_t x, input hz_stage_t m,
                                             input hz_stage_t w);
        if (!used || rs == '0) return {1'b0, FWD_NONE};
        if (x.valid && x.we && x.rd == rs)
            return (FWD_EN != 0 && x.ready) ? {1'b0, FWD_X} : {1'b1, FWD_NONE};
        if (m.valid && m.we && m.rd == rs)
            return (FWD_EN != 0 && m.ready) ? {1'b0, FWD_M} : {1'b1, FWD_NONE};
        if (w.valid && w.we && w.rd == rs)
            return (FWD_EN != 0 && w.ready) ? {1'b0, FWD_W} : {1'b1, FWD_NONE};
        return {1'b0, FWD_NONE};
    endfunction

    always_comb begin
        rs1_chk    = src_check(d_rs1_used_i, HZ_RD_W'(d_rs1_i), x_q, m_q, w_q);
        rs2_chk    = src_check(d_rs2_used_i, HZ_RD_W'(d_rs2_i), x_q, m_q, w_q);
        long_limit = d_is_long_i &&
                     (({1'b0, long_cnt} + 4'(x_q.valid & x_q.is_long)) >= 4'(MAX_LONG_OPS));
        any_stall  = rs1_chk[2] | rs2_chk[2] | (d_rs1_used_i & pend_rs1) |
                     (d_rs2_used_i & pend_rs2) | (d_rd_we_i & pend_rd) | long_limit;
        stall_o    = d_valid_i & any_stall & ~flush_i;
        issue_o    = d_valid_i & ~stall_o & ~flush_i & ~hold_i;
        fwd_rs1_sel_o = rs1_chk[1:0];
        fwd_rs2_sel_o = rs2_chk[1:0];
    end

    // A flush kills the op sitting in X, so it never reaches M or the scoreboard.
    always_comb begin
        x_d      = x_q;
        m_d      = m_q;
        w_d      = w_q;
        adv_long = ~hold_i & ~flush_i & x_q.valid & x_q.is_long;
        if (!hold_i) begin
            w_d       = m_q;
            m_d       = x_q;
            m_d.ready = ~x_q.is_long;
            if (flush_i) begin
                m_d = '0;
            end
            x_d = '0;
            if (issue_o) begin
                x_d.valid   = 1'b1;
                x_d.rd      = HZ_RD_W'(d_rd_i);
                x_d.we      = d_rd_we_i & (d_rd_i != '0);
                x_d.ready   = ~d_is_load_i & ~d_is_long_i;
                x_d.is_long = d_is_long_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            x_q <= x_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    long_op_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .REG_ADDR_W   (REG_ADDR_W),
        .MAX_LONG_OPS (MAX_LONG_OPS)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .set_i       (adv_long & x_q.we),
        .set_rd_i    (x_q.rd[REG_ADDR_W-1:0]),
        .inc_i       (adv_long),
        .done_i      (long_done_i),
        .done_rd_i   (long_done_rd_i),
        .look_rs1_i  (d_rs1_i),
        .look_rs2_i  (d_rs2_i),
        .look_rd_i   (d_rd_i),
        .pend_rs1_o  (pend_rs1),
        .pend_rs2_o  (pend_rs2),
        .pend_rd_o   (pend_rd),
        .long_cnt_o  (long_cnt),
        .long_busy_o (long_busy_o),
        .err_o       (err_o)
    );

endmodule
